// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART byte receiver.
package uart_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous inputs (serial line, buttons).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make this a true two-stage chain;
            // blocking ones would collapse both flops into one.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling; holds the last good byte for the
// 7-segment display driver and flags framing errors.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_indikators,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic rx_s;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // A start bit still low at its midpoint is real; otherwise it was a glitch.
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            // Leaving at the stop-bit midpoint gives half a bit of slack for
            // a back-to-back start edge.
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign data_indikators = data_q;
    assign data_valid      = valid_q;
    assign frame_error     = ferr_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_indikators;
    logic       data_valid;
    logic       busy;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int start_cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [6];

    uart_rx_byte #(
        .CLK_HZ (1600),
        .BAUD   (100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .data_indikators (data_indikators),
        .data_valid      (data_valid),
        .busy            (busy),
        .frame_error     (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each sampled cycle with data_valid high counts once, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (data_valid) begin
            pulse_cnt      = pulse_cnt + 1;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line back high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        idle_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle_clks(CPB);
        end
        rx = stop;
        idle_clks(CPB);
        rx = 1'b1;
    endtask

    initial begin
        int p0;
        int lat;

        vecs[0] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'hA5, exp_ferr: 1'b1, exp_pulses: 0};
        vecs[1] = '{data: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0, exp_pulses: 1};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0, exp_pulses: 1};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0, exp_pulses: 1};
        vecs[4] = '{data: 8'hFF, stop: 1'b0, exp_data: 8'h80, exp_ferr: 1'b1, exp_pulses: 0};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, exp_data: 8'h5A, exp_ferr: 1'b0, exp_pulses: 1};

        rx    = 1'b1;
        rst_n = 1'b0;
        idle_clks(3);
        check("reset_data", data_indikators, 8'h00);
        check("reset_valid", data_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_ferr", frame_error, 1'b0);
        rst_n = 1'b1;

        idle_clks(100);
        check("idle_no_pulse", pulse_cnt, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_data", data_indikators, 8'h00);

        // First good frame and rx-fall to data_valid latency.
        p0 = pulse_cnt;
        send_frame(8'hA5, 1'b1);
        idle_clks(CPB);
        lat = last_pulse_cyc - start_cyc;
        check("a5_data", data_indikators, 8'hA5);
        check("a5_pulses", pulse_cnt - p0, 1);
        check("a5_ferr", frame_error, 1'b0);
        check("a5_latency_154_156", (lat >= 154 && lat <= 156), 1'b1);

        // Three-clock glitch must be rejected at the start-bit midpoint.
        p0 = pulse_cnt;
        rx = 1'b0;
        idle_clks(3);
        rx = 1'b1;
        idle_clks(2);
        check("glitch_busy_seen", busy, 1'b1);
        idle_clks(20);
        check("glitch_busy_clear", busy, 1'b0);
        check("glitch_no_pulse", pulse_cnt - p0, 0);
        check("glitch_data", data_indikators, 8'hA5);

        for (int i = 0; i < 6; i++) begin
            p0 = pulse_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle_clks(2 * CPB);
            check($sformatf("vec%0d_data", i), data_indikators, vecs[i].exp_data);
            check($sformatf("vec%0d_ferr", i), frame_error, vecs[i].exp_ferr);
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Back-to-back frames with no idle gap.
        p0 = pulse_cnt;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle_clks(CPB);
        check("b2b_pulses", pulse_cnt - p0, 2);
        check("b2b_spacing", last_pulse_cyc - prev_pulse_cyc, 160);
        check("b2b_data", data_indikators, 8'h34);
        check("b2b_ferr", frame_error, 1'b0);

        // Break: line held low produces repeated error frames, never new data.
        p0 = pulse_cnt;
        rx = 1'b0;
        idle_clks(500);
        check("break_ferr", frame_error, 1'b1);
        check("break_no_pulse", pulse_cnt - p0, 0);
        check("break_data", data_indikators, 8'h34);
        rst_n = 1'b0;
        rx    = 1'b1;
        idle_clks(2);
        rst_n = 1'b1;
        idle_clks(20);
        check("break_rst_ferr", frame_error, 1'b0);
        check("break_rst_busy", busy, 1'b0);

        // Load a nonzero byte, then reset in the middle of bit 4 of a frame.
        send_frame(8'hC3, 1'b1);
        idle_clks(CPB);
        check("pre_rst_data", data_indikators, 8'hC3);
        rx = 1'b0;
        idle_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            idle_clks(CPB);
        end
        rx = 1'b0;
        idle_clks(CPB / 2);
        check("mid_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_indikators, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", data_valid, 1'b0);
        check("mid_rst_ferr", frame_error, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        idle_clks(2);
        rst_n = 1'b1;
        idle_clks(3 * CPB);
        check("post_rst_busy", busy, 1'b0);
        p0 = pulse_cnt;
        send_frame(8'hFF, 1'b1);
        idle_clks(CPB);
        check("post_rst_data", data_indikators, 8'hFF);
        check("post_rst_pulses", pulse_cnt - p0, 1);
        check("post_rst_ferr", frame_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Receives 8N1 asynchronous serial data on one input pin and recovers bytes using mid-bit sampling.
- Holds the last good byte on an 8-bit bus, which directly drives the data_indikators input of the 7-segment display driver.
- Sits upstream of the display driver and shares its board clock.
- Also provides a one-cycle valid strobe, a busy flag and a sticky framing-error flag.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (derived localparam, 5208 at defaults), clocks per bit; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (derived localparam, integer division), clocks from start edge to start-bit midpoint.

Ports:
- clk  input  1  board clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line; asynchronous to clk; idles high.
- data_indikators  output  8  last correctly framed byte; held until next good frame.
- data_valid  output  1  one-cycle pulse when data_indikators updates.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_error  output  1  high after a frame whose stop bit sampled 0; cleared by the next good frame.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE; bit counter=0; clock counter=0; shift register=0.
  - data_indikators=8'h00, data_valid=0, frame_error=0, busy=0.
  - Both synchronizer flops reset to 1 (line idle).
- rx passes through a 2-flop synchronizer; only the synchronized rx_s is used.
- Clock counter: ceiling CLKS_PER_BIT-1, cleared on every state transition and on every bit sample.
- IDLE:
  - rx_s==0 -> START; clock counter=0.
- START:
  - At clock counter==HALF_BIT-1, sample rx_s.
  - Sample 0 -> DATA; bit index=0; clock counter=0.
  - Sample 1 -> IDLE (glitch rejected, no outputs change).
- DATA:
  - At clock counter==CLKS_PER_BIT-1, sample rx_s.
  - Shift in LSB first: shift <= {rx_s, shift[7:1]}.
  - Bit index increments; after the 8th sample (bit index 7) -> STOP.
- STOP: at clock counter==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data_indikators<=final shift value, data_valid=1 for exactly one cycle, frame_error<=0.
  - Sample 0: frame_error<=1; data_indikators unchanged; no data_valid pulse.
  - Both cases -> IDLE on the same edge.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit midpoint, so a start bit arriving half a bit later is caught.
- Break condition (rx held low): after the error frame, IDLE sees rx_s==0 and starts a new frame. Each resulting frame flags frame_error; data is never updated.
- Latency from the rx falling edge to the data_valid pulse: 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks, ±1 for edge phase.
- data_valid is a registered output, low in every cycle except the update cycle.
- busy is combinational from state.
- Reset mid-frame: the partial byte is discarded, outputs return to reset values, and the FSM waits for a fresh falling edge.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Default BAUD/CLK_HZ constants.
- One natural sub-module: sync_2ff, a 1-bit two-flop synchronizer with asynchronous active-low reset and parameterized reset value (1 here). It is reusable for the button inputs.

Test Plan (sim parameters CLK_HZ=1600, BAUD=100, so CLKS_PER_BIT=16, HALF_BIT=8):
- Reset then idle line -> data_indikators=8'h00, data_valid never asserts, busy=0, frame_error=0.
- Frame 0xA5 (start 0, bits LSB-first 1,0,1,0,0,1,0,1, stop 1) -> data_indikators=8'hA5, single data_valid pulse about 155 clocks after the start edge, frame_error=0.
- 3-clock low glitch on rx -> FSM returns to IDLE at the start-midpoint check; no data_valid; data_indikators unchanged.
- Frame 0x3C with stop bit 0 -> frame_error=1, no data_valid, data_indikators holds the previous 8'hA5. Then a good frame 0x01 -> data_indikators=8'h01, frame_error=0.
- Back-to-back frames 0x12, 0x34 with no idle gap -> two data_valid pulses 160 clocks apart; final data_indikators=8'h34.
- rst_n asserted during bit 4 of a frame -> immediate reset values. A complete frame 0xFF sent after release -> data_indikators=8'hFF.
